// File: rtl/instr_encoder.sv
// Encodes field-level instruction requests into RV32I words, expanding the LI pseudo-op
// into ADDI or LUI(+ADDI). One registered output word buffer with a pending-ADDI slot.
module instr_encoder #(
  parameter int CNT_W    = 16,
  parameter bit LI_ELIDE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_kind,
  input  logic [2:0]       req_func3,
  input  logic             req_alt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLDA = 2'd2
  } state_t;

  localparam logic [2:0] K_OPR  = 3'd0;
  localparam logic [2:0] K_OPI  = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_BR   = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;
  localparam logic [2:0] K_LI   = 3'd6;

  state_t      state;
  logic [31:0] pending_addi;

  logic [31:0] first_word;
  logic [31:0] second_word;
  logic        two_word;
  logic        reject;
  logic [6:0]  f7;
  logic [31:0] li_sum;
  logic        li_small;
  logic        accept;
  logic        load;
  logic        out_fire;

  // Handshake: a request transfers on req_valid & req_ready; a word transfers on
  // out_valid & out_ready. req_ready is a pure function of state and out_ready.
  assign req_ready = (state == EMPTY) | ((state == HOLD1) & out_ready);
  assign accept    = req_valid & req_ready;
  assign load      = accept & ~reject;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    first_word  = 32'h0;
    second_word = 32'h0;
    two_word    = 1'b0;
    reject      = 1'b0;
    f7          = req_alt ? 7'b0100000 : 7'b0000000;
    li_sum      = req_imm + 32'h0000_0800;
    li_small    = (req_imm == {{20{req_imm[11]}}, req_imm[11:0]});
    case (req_kind)
      K_OPR: begin
        first_word = {f7, req_rs2, req_rs1, req_func3, req_rd, 7'b0110011};
        // Only SUB (000) and SRA (101) have an alternate func7.
        reject     = req_alt & (req_func3 != 3'b000) & (req_func3 != 3'b101);
      end
      K_OPI: begin
        if (req_func3 == 3'b001 || req_func3 == 3'b101)
          first_word = {f7, req_imm[4:0], req_rs1, req_func3, req_rd, 7'b0010011};
        else
          first_word = {req_imm[11:0], req_rs1, req_func3, req_rd, 7'b0010011};
        reject = req_alt & (req_func3 != 3'b101);
      end
      K_LW: first_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
      K_SW: first_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
      K_BR: begin
        first_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                      req_imm[4:1], req_imm[11], 7'b1100011};
        reject     = req_imm[0];
      end
      K_JAL: begin
        first_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                      req_rd, 7'b1101111};
        reject     = req_imm[0];
      end
      K_LI: begin
        // The +0x800 rounding compensates for ADDI sign-extending its low 12 bits.
        second_word = {req_imm[11:0], req_rd, 3'b000, req_rd, 7'b0010011};
        if (li_small) begin
          first_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, 7'b0010011};
        end else begin
          first_word = {li_sum[31:12], req_rd, 7'b0110111};
          two_word   = ~(LI_ELIDE && (req_imm[11:0] == 12'h000));
        end
      end
      default: first_word = {req_imm[11:0], req_rs1, req_func3, req_rd, 7'b1110011};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_last     <= 1'b0;
      err          <= 1'b0;
      words_sent   <= '0;
      pending_addi <= 32'h0;
    end else begin
      err <= accept & reject;
      if (out_fire)
        words_sent <= words_sent + CNT_W'(1);
      if (load) begin
        out_instr    <= first_word;
        pending_addi <= second_word;
        out_valid    <= 1'b1;
        out_last     <= ~two_word;
        state        <= two_word ? HOLDA : HOLD1;
      end else begin
        case (state)
          HOLD1: begin
            if (out_ready) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
          HOLDA: begin
            if (out_ready) begin
              state     <= HOLD1;
              out_instr <= pending_addi;
              out_last  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios from the encoding examples plus a
// randomized run scored against an arithmetic reference model and an expected-word queue.
module tb_instr_encoder;

  localparam int CNT_W = 16;
  localparam bit LI_ELIDE = 1'b1;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_kind;
  logic [2:0]       req_func3;
  logic             req_alt;
  logic [4:0]       req_rd;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [31:0]      req_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_last;
  logic             err;
  logic [CNT_W-1:0] words_sent;

  int n_vec;
  int n_miss;

  logic [32:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_err;

  instr_encoder #(.CNT_W(CNT_W), .LI_ELIDE(LI_ELIDE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_func3(req_func3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .err(err), .words_sent(words_sent)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    req_kind  = 3'd0;
    req_func3 = 3'd0;
    req_alt   = 1'b0;
    req_rd    = 5'd0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    req_imm   = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic [2:0] k, input logic [2:0] f3, input logic a,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    req_valid = 1'b1;
    req_kind  = k;
    req_func3 = f3;
    req_alt   = a;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
  endtask

  // Reference model: instruction fields placed by shifting into the word.
  function automatic void ref_encode(input logic [2:0] k, input logic [2:0] f3, input logic a,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm,
                                     output logic rej, output int n,
                                     output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] f7, d, s1, s2, fn, lo12, hi;
    f7   = a ? 32'h20 : 32'h0;
    d    = 32'(rd) << 7;
    s1   = 32'(rs1) << 15;
    s2   = 32'(rs2) << 20;
    fn   = 32'(f3) << 12;
    lo12 = imm & 32'hFFF;
    rej  = 1'b0;
    n    = 1;
    w1   = 32'h0;
    case (k)
      3'd0: begin
        w0  = (f7 << 25) | s2 | s1 | fn | d | 32'h33;
        rej = a && (f3 != 3'd0) && (f3 != 3'd5);
      end
      3'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) w0 = (f7 << 25) | ((imm & 32'h1F) << 20);
        else                          w0 = lo12 << 20;
        w0  = w0 | s1 | fn | d | 32'h13;
        rej = a && (f3 != 3'd5);
      end
      3'd2: w0 = (lo12 << 20) | s1 | (32'd2 << 12) | d | 32'h03;
      3'd3: w0 = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | (32'd2 << 12)
                 | ((imm & 32'h1F) << 7) | 32'h23;
      3'd4: begin
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | fn
             | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
        rej = imm[0];
      end
      3'd5: begin
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
        rej = imm[0];
      end
      3'd6: begin
        if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
          w0 = (lo12 << 20) | d | 32'h13;
        end else begin
          hi = (imm + 32'h800) >> 12;
          w0 = (hi << 12) | d | 32'h37;
          w1 = (lo12 << 20) | (32'(rd) << 15) | d | 32'h13;
          n  = (LI_ELIDE && lo12 == 32'h0) ? 1 : 2;
        end
      end
      default: w0 = (lo12 << 20) | s1 | fn | d | 32'h73;
    endcase
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_instr !== 32'h0) begin n_miss++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_vec++; if (out_last !== 1'b0) begin n_miss++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (words_sent !== '0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", words_sent); end
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_opr();
    apply_reset();
    out_ready = 1'b1;
    drive_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL opr_valid: got %b want 1", out_valid); end
    n_vec++; if (out_instr !== 32'h002081B3) begin n_miss++; $display("FAIL opr_word: got %h want 002081b3", out_instr); end
    n_vec++; if (out_last !== 1'b1) begin n_miss++; $display("FAIL opr_last: got %b want 1", out_last); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL opr_drain: got %b want 0", out_valid); end
    n_vec++; if (words_sent !== 16'd1) begin n_miss++; $display("FAIL opr_count: got %0d want 1", words_sent); end
  endtask

  task automatic test_li_pair(input string nm, input logic [4:0] rd, input logic [31:0] imm,
                              input logic [31:0] lui_w, input logic [31:0] addi_w);
    apply_reset();
    out_ready = 1'b1;
    drive_req(3'd6, 3'd0, 1'b0, rd, 5'd0, 5'd0, imm);
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_instr !== lui_w || out_last !== 1'b0) begin n_miss++;
      $display("FAIL %s_lui: got %h last %b want %h last 0", nm, out_instr, out_last, lui_w); end
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL %s_ready: got %b want 0", nm, req_ready); end
    tick();
    n_vec++; if (out_instr !== addi_w || out_last !== 1'b1 || out_valid !== 1'b1) begin n_miss++;
      $display("FAIL %s_addi: got %h last %b want %h last 1", nm, out_instr, out_last, addi_w); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd2) begin n_miss++;
      $display("FAIL %s_end: got valid %b count %0d want 0/2", nm, out_valid, words_sent); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    drive_req(3'd6, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF);
    tick();
    n_vec++; if (out_instr !== 32'hFFF00113 || out_last !== 1'b1) begin n_miss++;
      $display("FAIL b2b_first: got %h last %b want fff00113 last 1", out_instr, out_last); end
    drive_req(3'd6, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h00001000);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_instr !== 32'h00001237 || out_last !== 1'b1 || words_sent !== 16'd1) begin n_miss++;
      $display("FAIL b2b_second: got %h last %b count %0d want 00001237 last 1 count 1", out_instr, out_last, words_sent); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd2) begin n_miss++;
      $display("FAIL b2b_end: got valid %b count %0d want 0/2", out_valid, words_sent); end
  endtask

  task automatic test_reject();
    apply_reset();
    out_ready = 1'b1;
    drive_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3);
    tick();
    req_valid = 1'b0;
    n_vec++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_miss++;
      $display("FAIL rej_pulse: got err %b valid %b want 1/0", err, out_valid); end
    tick();
    n_vec++; if (err !== 1'b0 || out_valid !== 1'b0) begin n_miss++;
      $display("FAIL rej_clear: got err %b valid %b want 0/0", err, out_valid); end
    drive_req(3'd0, 3'd0, 1'b1, 5'd7, 5'd6, 5'd5, 32'h0);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rej_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_instr !== 32'h405303B3 || out_last !== 1'b1) begin n_miss++;
      $display("FAIL rej_next: got %h want 405303b3", out_instr); end
  endtask

  task automatic test_stall_holda();
    apply_reset();
    out_ready = 1'b0;
    drive_req(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    tick();
    drive_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (out_instr !== 32'h123452B7 || out_last !== 1'b0 || out_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_miss++; $display("FAIL stall_hold%0d: got %h last %b valid %b ready %b want 123452b7/0/1/0",
                           i, out_instr, out_last, out_valid, req_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL stall_ready: got %b want 0", req_ready); end
    tick();
    n_vec++; if (out_instr !== 32'h67828293 || out_last !== 1'b1) begin n_miss++;
      $display("FAIL stall_addi: got %h want 67828293", out_instr); end
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_instr !== 32'h002081B3 || out_last !== 1'b1) begin n_miss++;
      $display("FAIL stall_queued: got %h want 002081b3", out_instr); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd3) begin n_miss++;
      $display("FAIL stall_end: got valid %b count %0d want 0/3", out_valid, words_sent); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    drive_req(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    tick();
    req_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin n_miss++;
      $display("FAIL mid_holda: got valid %b last %b want 1/0", out_valid, out_last); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd0) begin n_miss++;
      $display("FAIL mid_reset: got valid %b count %0d want 0/0", out_valid, words_sent); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd0) begin n_miss++;
        $display("FAIL mid_noaddi%0d: got valid %b count %0d want 0/0", i, out_valid, words_sent); end
    end
  endtask

  task automatic test_random(input int cycles);
    logic        m_ready, rej;
    int          n;
    logic [31:0] w0, w1, imm;
    logic [31:0] edge_imm[6];
    edge_imm = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF, 32'h7FFFF800, 32'h80000000};
    apply_reset();
    exp_q.delete();
    exp_cnt = '0;
    exp_err = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_miss++;
        $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if ({out_last, out_instr} !== exp_q[0]) begin n_miss++;
          $display("FAIL rnd_word@%0d: got %b/%h want %b/%h", c, out_last, out_instr, exp_q[0][32], exp_q[0][31:0]); end
      end
      n_vec++; if (err !== exp_err) begin n_miss++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, exp_err); end
      n_vec++; if (words_sent !== exp_cnt) begin n_miss++;
        $display("FAIL rnd_count@%0d: got %0d want %0d", c, words_sent, exp_cnt); end
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = edge_imm[$urandom_range(0, 5)] ^ 32'($urandom_range(0, 1));
      endcase
      drive_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                5'($urandom), 5'($urandom), 5'($urandom), imm);
      req_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      n_vec++; if (req_ready !== m_ready) begin n_miss++;
        $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, m_ready); end
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      exp_err = 1'b0;
      if (req_valid && m_ready) begin
        ref_encode(req_kind, req_func3, req_alt, req_rd, req_rs1, req_rs2, req_imm, rej, n, w0, w1);
        if (rej) exp_err = 1'b1;
        else if (n == 1) exp_q.push_back({1'b1, w0});
        else begin
          exp_q.push_back({1'b0, w0});
          exp_q.push_back({1'b1, w1});
        end
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    req_kind  = 3'd0;
    req_func3 = 3'd0;
    req_alt   = 1'b0;
    req_rd    = 5'd0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    req_imm   = 32'h0;
    @(negedge clk);
    test_reset();
    test_opr();
    test_li_pair("li_big", 5'd5, 32'h12345678, 32'h123452B7, 32'h67828293);
    test_li_pair("li_carry", 5'd1, 32'h00000800, 32'h000010B7, 32'h80008093);
    test_back_to_back();
    test_reject();
    test_stall_holda();
    test_reset_mid();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
